axi_wr_master: RTL
==================

# axi_wr_master

Single-outstanding AXI4 write-channel master that turns a simple command/data request stream into AW, W and B channel traffic. It is the stage directly upstream of our AXI slave write port and drives its `s_axi_aw*`, `s_axi_w*` and `s_axi_bready` inputs. It returns one completion per command to the requester. AW and W are strictly serialised, matching the slave's acceptance order: AW completes before the first W beat.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width; STRB_W = DATA_W/8
- ID_W, 12, transaction ID width
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_addr, cmd_len, cmd_size, cmd_burst, cmd_id  in  ADDR_W, 8, 3, 2, ID_W  burst descriptor (beats = cmd_len+1)
- wr_valid / wr_ready  in / out  1 / 1  write-data handshake
- wr_data, wr_strb  in  DATA_W, STRB_W  beat payload
- m_axi_awvalid  out  1; m_axi_awready  in  1
- m_axi_awaddr, awlen, awsize, awburst, awid  out  ADDR_W, 8, 3, 2, ID_W
- m_axi_awlock, awcache, awprot, awqos  out  1, 4, 3, 4  constants 0, 4'b0011, 0, 0
- m_axi_wvalid  out  1; m_axi_wready  in  1
- m_axi_wdata, wstrb, wid, wlast  out  DATA_W, STRB_W, ID_W, 1
- m_axi_bvalid  in  1; m_axi_bready  out  1; m_axi_bid, m_axi_bresp  in  ID_W, 2
- resp_valid  out  1  one-cycle completion pulse
- resp_code  out  2  returned BRESP, or 2'b10 for a locally rejected command
- resp_id_err  out  1  BID differed from the stored ID (valid with resp_valid)

## Operation
- FSM states: IDLE, AW, W, B.
- IDLE: `cmd_ready=1`, combinational on state, 0 while rst is high.
  - On `cmd_valid`, latch the descriptor and clear `beat_cnt` (9 bit).
  - If `cmd_burst==2'b11` (reserved): stay in IDLE, pulse `resp_valid` next cycle with `resp_code=2'b10` and `resp_id_err=0`. No AXI traffic is issued.
  - Otherwise go to AW.
- AW: `m_axi_awvalid=1`, with the aw fields held from the latch. On `awready` go to W. `awvalid` drops the same edge.
- W: uses a one-entry output register (`wvalid`, `wdata`, `wstrb`, `wlast`). `wid` equals the latched ID.
  - `wr_ready = (state==W) && (beat_cnt <= len) && (!m_axi_wvalid || m_axi_wready)`.
  - On `wr_valid && wr_ready`: load the register, set `wvalid`, set `wlast = (beat_cnt==len)`, increment `beat_cnt`.
  - On `wvalid && wready` with no new load: clear `wvalid`.
  - Back-to-back beats sustain one per cycle.
  - When the wlast beat handshakes, go to B.
- B: `m_axi_bready=1`. On `bvalid`, pulse `resp_valid` the next cycle with `resp_code=bresp` and `resp_id_err=(bid!=id)`, and return to IDLE.
- AXI rules:
  - A valid, once asserted, never drops and its payload never changes until the handshake.
  - No valid depends combinationally on a ready.
- Reset values: all valids, `bready`, `wlast` and `resp_*` are 0. All registered aw/w payloads are 0. State is IDLE.
- Reset mid-burst: the FSM returns to IDLE and all valids are 0 on the cycle after rst. No completion is reported. The partial burst is abandoned; the downstream slave is reset in the same domain.

## Timing
- Command accepted at edge N: `awvalid` is high from N+1.
- With `awready` already high: AW handshake at N+1, `wr_ready` high from N+2.
- A beat accepted at edge M is visible on `m_axi_w*` from M+1.
- The minimum burst of len=0 with always-ready slave and source:
  - cmd at N, AW at N+1, beat in at N+2, W handshake at N+3, B handshake at N+4 or later, `resp_valid` at N+5.
- `cmd_ready` is 0 from N+1 until the cycle after the B handshake. Exactly one command is in flight.
- len=255: 256 beats; `beat_cnt` 9-bit, never wraps.
- `bvalid` arriving early (in AW/W) is ignored; `bready` stays 0 outside state B.

## Test plan
- Single beat, addr 0x1000, len 0, id 0x5A, always-ready slave, B OKAY -> one AW (awlen 0), one W with wlast=1 and wid 0x5A; `resp_valid` pulse with `resp_code=0`, `resp_id_err=0`; `cmd_ready` high again.
- len 3, wready toggling 1-0-1-0 and wr_valid gaps -> exactly 4 W handshakes; data in order; wlast only on the 4th; payload stable while wvalid && !wready.
- awready held low for 10 cycles -> awvalid and awaddr stable all 10 cycles; no `wr_ready` before the AW handshake.
- `cmd_burst=2'b11` -> no awvalid; `resp_valid` with `resp_code=2'b10` one cycle after accept.
- B returns bid 0x3 for id 0x5, bresp 2'b10 -> `resp_id_err=1`, `resp_code=2'b10`.
- rst asserted during beat 2 of len 7 -> all valids 0 the next cycle, no `resp_valid`; a new command is then accepted and completes normally.

Source files
------------

// File: rtl/axi_wr_master.sv
// Single-outstanding AXI4 write master.
// Turns one command plus its data beats into AW, then W, then B traffic.
// Returns exactly one completion pulse per accepted command.
// Reserved-burst commands are rejected locally with SLVERR and issue no AXI traffic.
module axi_wr_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 12,
  parameter int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  // command stream
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [7:0]        cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [ID_W-1:0]   cmd_id,
  // write-data stream
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  // AXI write address channel
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [7:0]        m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [ID_W-1:0]   m_axi_awid,
  output logic              m_axi_awlock,
  output logic [3:0]        m_axi_awcache,
  output logic [2:0]        m_axi_awprot,
  output logic [3:0]        m_axi_awqos,
  // AXI write data channel
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic [ID_W-1:0]   m_axi_wid,
  output logic              m_axi_wlast,
  // AXI write response channel
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [ID_W-1:0]   m_axi_bid,
  input  logic [1:0]        m_axi_bresp,
  // completion
  output logic              resp_valid,
  output logic [1:0]        resp_code,
  output logic              resp_id_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_AW, ST_W, ST_B} state_t;

  localparam logic [1:0] BURST_RSVD = 2'b11;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [7:0]          r_len;
  logic [2:0]          r_size;
  logic [1:0]          r_burst;
  logic [ID_W-1:0]     r_id;
  logic [8:0]          r_beat_cnt;   // 9 bits so len=255 reaches 256 without wrapping
  logic                r_awvalid;
  logic                r_wvalid;
  logic [DATA_W-1:0]   r_wdata;
  logic [STRB_W-1:0]   r_wstrb;
  logic                r_wlast;
  logic                r_bready;
  logic                r_resp_valid;
  logic [1:0]          r_resp_code;
  logic                r_resp_id_err;

  logic                w_wr_ready;
  logic                w_wr_fire;
  logic                w_w_fire;

  // Source may push a beat while beats remain and the output register is free or draining.
  assign w_wr_ready = (r_state == ST_W) && (r_beat_cnt <= {1'b0, r_len}) &&
                      (!r_wvalid || m_axi_wready);
  assign w_wr_fire  = wr_valid && w_wr_ready;
  assign w_w_fire   = r_wvalid && m_axi_wready;

  assign cmd_ready     = (r_state == ST_IDLE) && !rst;
  assign wr_ready      = w_wr_ready;

  assign m_axi_awvalid = r_awvalid;
  assign m_axi_awaddr  = r_addr;
  assign m_axi_awlen   = r_len;
  assign m_axi_awsize  = r_size;
  assign m_axi_awburst = r_burst;
  assign m_axi_awid    = r_id;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;

  assign m_axi_wvalid  = r_wvalid;
  assign m_axi_wdata   = r_wdata;
  assign m_axi_wstrb   = r_wstrb;
  assign m_axi_wid     = r_id;
  assign m_axi_wlast   = r_wlast;

  assign m_axi_bready  = r_bready;

  assign resp_valid    = r_resp_valid;
  assign resp_code     = r_resp_code;
  assign resp_id_err   = r_resp_id_err;

  // Transaction FSM with every channel output registered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (rst) begin
      r_state       <= ST_IDLE;
      r_addr        <= '0;
      r_len         <= '0;
      r_size        <= '0;
      r_burst       <= '0;
      r_id          <= '0;
      r_beat_cnt    <= '0;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_wdata       <= '0;
      r_wstrb       <= '0;
      r_wlast       <= 1'b0;
      r_bready      <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_code   <= '0;
      r_resp_id_err <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr     <= cmd_addr;
            r_len      <= cmd_len;
            r_size     <= cmd_size;
            r_burst    <= cmd_burst;
            r_id       <= cmd_id;
            r_beat_cnt <= '0;
            if (cmd_burst == BURST_RSVD) begin
              r_resp_valid  <= 1'b1;
              r_resp_code   <= RESP_SLVERR;
              r_resp_id_err <= 1'b0;
            end else begin
              r_awvalid <= 1'b1;
              r_state   <= ST_AW;
            end
          end
        end
        ST_AW: begin
          if (m_axi_awready) begin
            r_awvalid <= 1'b0;
            r_state   <= ST_W;
          end
        end
        ST_W: begin
          if (w_wr_fire) begin
            r_wvalid   <= 1'b1;
            r_wdata    <= wr_data;
            r_wstrb    <= wr_strb;
            r_wlast    <= (r_beat_cnt == {1'b0, r_len});
            r_beat_cnt <= r_beat_cnt + 9'd1;
          end else if (w_w_fire) begin
            r_wvalid <= 1'b0;
          end
          // After the last beat is loaded no further load can occur, so this drain is final.
          if (w_w_fire && r_wlast) begin
            r_bready <= 1'b1;
            r_state  <= ST_B;
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            r_bready      <= 1'b0;
            r_resp_valid  <= 1'b1;
            r_resp_code   <= m_axi_bresp;
            r_resp_id_err <= (m_axi_bid != r_id);
            r_state       <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
